// File: rtl/obi_err_sbr.sv
// OBI error subordinate: accepts every request, queues it in a small FIFO and
// returns an in-order error response once the entry has aged RspLatency cycles.
module obi_err_sbr #(
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned IdWidth     = 1,
    parameter int unsigned ErrBits     = 1,
    parameter int unsigned NumMaxTrans = 2,
    parameter int unsigned RspLatency  = 1,
    parameter logic [31:0] RspData     = 32'hBADCAB1E
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 obi_req_i,
    output logic                 obi_gnt_o,
    input  logic [AddrWidth-1:0] obi_addr_i,
    input  logic                 obi_we_i,
    input  logic [IdWidth-1:0]   obi_aid_i,
    output logic                 obi_rvalid_o,
    input  logic                 obi_rready_i,
    output logic [DataWidth-1:0] obi_rdata_o,
    output logic [IdWidth-1:0]   obi_rid_o,
    output logic [ErrBits-1:0]   obi_err_o,
    output logic [AddrWidth-1:0] err_addr_o,
    output logic [31:0]          err_cnt_o
);

    localparam int unsigned PtrWidth = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
    localparam int unsigned CntWidth = $clog2(NumMaxTrans + 1);
    localparam int unsigned AgeWidth = $clog2(RspLatency + 1);

    localparam logic [AgeWidth-1:0]  AgeMax  = AgeWidth'(RspLatency);
    localparam logic [PtrWidth-1:0]  PtrLast = PtrWidth'(NumMaxTrans - 1);
    localparam logic [CntWidth-1:0]  CntFull = CntWidth'(NumMaxTrans);
    localparam logic [DataWidth-1:0] RdData  = DataWidth'(RspData);

    logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntWidth-1:0]  count_q, count_d;
    logic [AddrWidth-1:0] err_addr_q, err_addr_d;
    logic [31:0]          err_cnt_q, err_cnt_d;

    logic                 slot_vld  [NumMaxTrans];
    logic [AgeWidth-1:0]  slot_age  [NumMaxTrans];
    logic [IdWidth-1:0]   slot_aid  [NumMaxTrans];
    logic [AddrWidth-1:0] slot_addr [NumMaxTrans];
    logic                 slot_we   [NumMaxTrans];

    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 rvalid;
    logic                 head_vld;
    logic [AgeWidth-1:0]  head_age;
    logic [IdWidth-1:0]   head_aid;
    logic [AddrWidth-1:0] head_addr;
    logic                 head_we;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    // Grant only looks at the registered fill level, never at the response side.
    assign full      = (count_q == CntFull);
    assign obi_gnt_o = obi_req_i & ~full & ~rst_i;
    assign push      = obi_gnt_o;

    assign head_vld  = slot_vld[rd_ptr_q];
    assign head_age  = slot_age[rd_ptr_q];
    assign head_aid  = slot_aid[rd_ptr_q];
    assign head_addr = slot_addr[rd_ptr_q];
    assign head_we   = slot_we[rd_ptr_q];

    assign rvalid = head_vld && (head_age == AgeMax);
    assign pop    = rvalid & obi_rready_i;

    for (genvar gi = 0; gi < NumMaxTrans; gi++) begin : g_slot
        logic                 vld_q, vld_d;
        logic [AgeWidth-1:0]  age_q, age_d;
        logic [IdWidth-1:0]   aid_q, aid_d;
        logic [AddrWidth-1:0] addr_q, addr_d;
        logic                 we_q, we_d;
        logic                 push_here;
        logic                 pop_here;

        assign push_here = push && (wr_ptr_q == PtrWidth'(gi));
        assign pop_here  = pop && (rd_ptr_q == PtrWidth'(gi));

        // The grant cycle counts as the first aging step, so a fresh entry starts at 1.
        always_comb begin
            vld_d  = vld_q;
            age_d  = age_q;
            aid_d  = aid_q;
            addr_d = addr_q;
            we_d   = we_q;
            if (vld_q && (age_q != AgeMax)) begin
                age_d = age_q + 1'b1;
            end
            if (pop_here) begin
                vld_d = 1'b0;
            end
            if (push_here) begin
                vld_d  = 1'b1;
                age_d  = AgeWidth'(1);
                aid_d  = obi_aid_i;
                addr_d = obi_addr_i;
                we_d   = obi_we_i;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_q  <= 1'b0;
                age_q  <= '0;
                aid_q  <= '0;
                addr_q <= '0;
                we_q   <= 1'b0;
            end else begin
                vld_q  <= vld_d;
                age_q  <= age_d;
                aid_q  <= aid_d;
                addr_q <= addr_d;
                we_q   <= we_d;
            end
        end

        assign slot_vld[gi]  = vld_q;
        assign slot_age[gi]  = age_q;
        assign slot_aid[gi]  = aid_q;
        assign slot_addr[gi] = addr_q;
        assign slot_we[gi]   = we_q;
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d   = ptr_inc(rd_ptr_q);
            err_addr_d = head_addr;
            if (err_cnt_q != 32'hFFFF_FFFF) begin
                err_cnt_d = err_cnt_q + 32'd1;
            end
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign obi_rvalid_o = rvalid;
    assign obi_rid_o    = head_aid;
    assign obi_rdata_o  = head_we ? '0 : RdData;
    assign obi_err_o    = {ErrBits{rvalid}};
    assign err_addr_o   = err_addr_q;
    assign err_cnt_o    = err_cnt_q;

endmodule
